rcc_wkup_rst_sync_mux: RTL and testbench
========================================

# rcc_wkup_rst_sync_mux

Parametrised reset/wakeup conditioning block for the RCC vcore domain. It takes N_CH asynchronous raw wakeup/reset requests of per-channel polarity and synchronises each one into `clk`. Each request is stretched to a guaranteed minimum pulse width, and the block then applies the DFT test-reset override per channel. It sits between the PWR wakeup sources and the RCC domain reset logic, with one instance per clock domain.

## Interface
Parameters:
- N_CH, 3: number of request channels (1..32).
- ACT_HIGH, {N_CH{1'b1}}: per-channel polarity of both raw input and output; bit=1 means active-high.
- SYNC_STAGES, 2: synchroniser depth (2..4).
- MIN_PULSE, 8: minimum output assertion length in `clk` cycles (1..255).
- CNT_W, $clog2(MIN_PULSE+1): derived pulse counter width. Not for override.

Ports:
- clk  input  1  domain clock; one clock only.
- rst_n  input  1  asynchronous active-low reset. Assertion is asynchronous; release is synchronous to `clk` upstream.
- raw_req  input  N_CH  asynchronous requests; polarity per ACT_HIGH.
- testmode  input  1  static DFT mode; selects the test reset path.
- test_rst_n  input  1  DFT reset, active-low.
- evt_clr  input  N_CH  write-1-to-clear strobes for evt_flag, one `clk` cycle.
- req_out  output  N_CH  conditioned requests; polarity per ACT_HIGH.
- evt_flag  output  N_CH  sticky per-channel "assertion occurred" flags.
- busy  output  1  OR of all channel FSMs not in IDLE.

## Operation
Input normalisation:
- For each channel i, n_req[i] = raw_req[i] XNOR ACT_HIGH[i]. The internal domain is active-high.

Synchroniser:
- SYNC_STAGES flops per channel on n_req. Reset value is 0 (inactive). The last stage is req_s[i].

Per-channel FSM (2-bit state, CNT_W counter):
- IDLE: stretched=0. If req_s=1, go to ASSERT and load cnt=MIN_PULSE-1.
- ASSERT: stretched=1. If cnt≠0, cnt-=1. If cnt==0, go to HOLD when req_s=1, otherwise go to IDLE.
- HOLD: stretched=1. When req_s=0, go to IDLE.
- Any illegal state encoding goes to IDLE.
- A req_s deassertion during ASSERT is ignored; the pulse always completes MIN_PULSE cycles.
- A req_s reassertion in the IDLE cycle directly after ASSERT/HOLD starts a new ASSERT. There is no dead time enforced beyond the single IDLE cycle.

Output:
- stretched[i] is registered.
- Functional value: func_out[i] = stretched[i] XNOR ACT_HIGH[i].
- req_out[i] = testmode ? (ACT_HIGH[i] ? ~test_rst_n : test_rst_n) : func_out[i]. The test path is combinational, so it has no flop between test_rst_n and req_out.
- The FSMs keep running during testmode. Only the output is overridden.

Event flags:
- evt_flag[i] is set on the IDLE→ASSERT transition.
- It is cleared by evt_clr[i]=1.
- If set and clear occur in the same cycle, set wins.

Busy:
- busy = |(state≠IDLE), registered view of state (no extra flop).

Reset (rst_n=0):
- Sync flops=0, FSM=IDLE, cnt=0, evt_flag=0, busy=0.
- req_out = inactive level per ACT_HIGH when testmode=0; the test value otherwise.
- Reset mid-pulse aborts immediately and asynchronously to the inactive level.

## Timing
- Assertion latency: raw edge captured at clk edge k gives req_out active after edge k+SYNC_STAGES. That is SYNC_STAGES+1 cycles worst case from the asynchronous edge.
- Width: a raw pulse of W cycles (stable ≥1 sampling) gives an output width of max(W, MIN_PULSE) ±1 cycle. A glitch shorter than one cycle may be missed or stretched; either is legal.
- Deassertion latency after MIN_PULSE has expired: SYNC_STAGES+1 cycles.
- With MIN_PULSE=1, ASSERT lasts exactly one cycle.
- testmode/test_rst_n to req_out: combinational, zero cycles.
- Channels are fully independent. Simultaneous requests on all channels assert in the same cycle.

## Test plan
Configuration for all scenarios: N_CH=3, ACT_HIGH=3'b011, SYNC_STAGES=2, MIN_PULSE=8.

- Reset: rst_n=0, testmode=0 → req_out=3'b100, evt_flag=0, busy=0. Assert rst_n mid-pulse on ch0 → req_out[0]=0 asynchronously.
- Short pulse: raw_req[0]=1 for 2 cycles → req_out[0] high for exactly 8 cycles, starting 2 cycles after the sampling edge. evt_flag[0]=1 and busy=1 during the pulse.
- Long pulse plus active-low channel: raw_req[2]=0 for 20 cycles → req_out[2]=0 for 20 cycles, delayed 2 cycles on both edges, with the FSM passing through HOLD.
- Back-to-back: raw_req[1] pulse of 1 cycle, then reasserted 9 cycles later → two distinct 8-cycle pulses separated by ≥1 inactive cycle. evt_flag[1] is set. evt_clr[1] in the same cycle as the second set leaves the flag at 1.
- Testmode override: testmode=1, test_rst_n=0 → req_out=3'b011 immediately. test_rst_n=1 → req_out=3'b100. Concurrent raw activity has no effect on req_out, but evt_flag still updates.
- Simultaneous channels: all channels requested in the same cycle → all req_out assert in the same cycle and all evt_flag bits set together.

Source files
------------

// File: rtl/rcc_wkup_rst_sync_mux.sv
// Reset/wakeup request conditioning: per-channel synchroniser, minimum-width
// pulse stretcher, sticky event flags and DFT test-reset override.
module rcc_wkup_rst_sync_mux #(
  parameter int unsigned        N_CH        = 3,
  parameter logic [N_CH-1:0]    ACT_HIGH    = {N_CH{1'b1}},
  parameter int unsigned        SYNC_STAGES = 2,
  parameter int unsigned        MIN_PULSE   = 8,
  parameter int unsigned        CNT_W       = $clog2(MIN_PULSE + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] raw_req,
  input  logic            testmode,
  input  logic            test_rst_n,
  input  logic [N_CH-1:0] evt_clr,
  output logic [N_CH-1:0] req_out,
  output logic [N_CH-1:0] evt_flag,
  output logic            busy
);

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ASSERT = 2'b01;
  localparam logic [1:0] ST_HOLD   = 2'b10;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MIN_PULSE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q, sync_d;
  logic [N_CH-1:0][1:0]             state_q, state_d;
  logic [N_CH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [N_CH-1:0]                  evt_flag_q, evt_flag_d;
  logic [N_CH-1:0]                  n_req;
  logic [N_CH-1:0]                  req_s;
  logic [N_CH-1:0]                  stretched;

  // Normalise to active-high and shift through the synchroniser chain.
  always_comb begin
    n_req     = ~(raw_req ^ ACT_HIGH);
    sync_d    = sync_q;
    sync_d[0] = n_req;
    for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
    req_s = sync_q[SYNC_STAGES-1];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    evt_flag_d = evt_flag_q;
    for (int unsigned i = 0; i < N_CH; i++) begin
      // Set has priority over a same-cycle clear.
      evt_flag_d[i] = evt_flag_q[i] & ~evt_clr[i];
      case (state_q[i])
        ST_IDLE: begin
          if (req_s[i]) begin
            state_d[i]    = ST_ASSERT;
            cnt_d[i]      = CNT_LOAD;
            evt_flag_d[i] = 1'b1;
          end
        end
        ST_ASSERT: begin
          if (cnt_q[i] != '0) begin
            cnt_d[i] = cnt_q[i] - CNT_ONE;
          end else begin
            state_d[i] = req_s[i] ? ST_HOLD : ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (!req_s[i]) begin
            state_d[i] = ST_IDLE;
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      state_q    <= '0;
      cnt_q      <= '0;
      evt_flag_q <= '0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      evt_flag_q <= evt_flag_d;
    end
  end

  // Test override is purely combinational so DFT reset reaches req_out with no flop.
  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      stretched[i] = (state_q[i] != ST_IDLE);
      if (testmode) begin
        req_out[i] = ACT_HIGH[i] ? ~test_rst_n : test_rst_n;
      end else begin
        req_out[i] = ~(stretched[i] ^ ACT_HIGH[i]);
      end
    end
    busy     = |stretched;
    evt_flag = evt_flag_q;
  end

endmodule

// File: tb/tb_rcc_wkup_rst_sync_mux.sv
// Randomised and directed bench for rcc_wkup_rst_sync_mux against a
// cycle-level behavioural model (N_CH=3, ACT_HIGH=3'b011, 2 stages, MIN_PULSE=8).
module tb_rcc_wkup_rst_sync_mux;

  localparam int          N  = 3;
  localparam logic [2:0]  AH = 3'b011;
  localparam int          SS = 2;
  localparam int          MP = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] raw_req;
  logic       testmode;
  logic       test_rst_n;
  logic [2:0] evt_clr;
  logic [2:0] req_out;
  logic [2:0] evt_flag;
  logic       busy;

  rcc_wkup_rst_sync_mux #(
    .N_CH        (N),
    .ACT_HIGH    (AH),
    .SYNC_STAGES (SS),
    .MIN_PULSE   (MP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw_req    (raw_req),
    .testmode   (testmode),
    .test_rst_n (test_rst_n),
    .evt_clr    (evt_clr),
    .req_out    (req_out),
    .evt_flag   (evt_flag),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: delay line of normalised requests, active flag and cycles-active age.
  bit m_s   [N][SS];
  bit m_act [N];
  int m_age [N];
  bit m_flag[N];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      for (int s = 0; s < SS; s++) m_s[i][s] = 1'b0;
      m_act[i]  = 1'b0;
      m_age[i]  = 0;
      m_flag[i] = 1'b0;
    end
  endtask

  function automatic logic [2:0] exp_req_out();
    logic [2:0] r;
    for (int i = 0; i < N; i++) begin
      if (testmode) r[i] = AH[i] ? ~test_rst_n : test_rst_n;
      else          r[i] = m_act[i] ? AH[i] : ~AH[i];
    end
    return r;
  endfunction

  function automatic logic [2:0] exp_flag();
    logic [2:0] r;
    for (int i = 0; i < N; i++) r[i] = m_flag[i];
    return r;
  endfunction

  function automatic logic exp_busy();
    logic b = 1'b0;
    for (int i = 0; i < N; i++) b |= m_act[i];
    return b;
  endfunction

  task automatic compare_all(input string tag);
    check_val({tag, ".req_out"},  req_out,  exp_req_out());
    check_val({tag, ".evt_flag"}, evt_flag, exp_flag());
    check_val({tag, ".busy"},     busy,     exp_busy());
  endtask

  // Inputs are stable from the preceding falling edge; advance one clock and compare.
  task automatic step(input string tag);
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < N; i++) begin
        bit rs  = m_s[i][SS-1];
        bit nxt = m_act[i] ? ((m_age[i] < MP) || rs) : rs;
        if (!m_act[i] && nxt) m_flag[i] = 1'b1;
        else if (evt_clr[i])  m_flag[i] = 1'b0;
        m_age[i] = nxt ? (m_act[i] ? m_age[i] + 1 : 1) : 0;
        m_act[i] = nxt;
        for (int s = SS - 1; s > 0; s--) m_s[i][s] = m_s[i][s-1];
        m_s[i][0] = (raw_req[i] == AH[i]);
      end
    end
    #1;
    compare_all(tag);
    @(negedge clk);
  endtask

  int hi;

  initial begin
    rst_n      = 1'b0;
    testmode   = 1'b0;
    test_rst_n = 1'b1;
    raw_req    = ~AH;
    evt_clr    = '0;
    model_reset();
    #2;
    check_val("reset.req_out",  req_out,  3'b100);
    check_val("reset.evt_flag", evt_flag, 3'b000);
    check_val("reset.busy",     busy,     1'b0);
    step("reset");
    step("reset");
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) step("idle");

    // Short pulse on ch0: 2 cycles raw -> 8 cycles out.
    hi = 0;
    for (int k = 0; k < 16; k++) begin
      raw_req[0] = (k < 2);
      step("short");
      if (req_out[0]) hi++;
    end
    check_val("short.width", hi, MP);

    // Long active-low pulse on ch2: 20 cycles raw -> 20 cycles out.
    hi = 0;
    for (int k = 0; k < 28; k++) begin
      raw_req[2] = !(k < 20);
      step("long");
      if (!req_out[2]) hi++;
    end
    check_val("long.width", hi, 20);

    // Back-to-back on ch1; clear at k=5, then clear coincident with the second set at k=11.
    hi = 0;
    for (int k = 0; k < 24; k++) begin
      raw_req[1] = (k == 0) || (k == 9);
      evt_clr[1] = (k == 5) || (k == 11);
      step("b2b");
      if (req_out[1]) hi++;
      if (k == 5)  check_val("b2b.cleared", evt_flag[1], 1'b0);
      if (k == 11) check_val("b2b.set_wins", evt_flag[1], 1'b1);
    end
    evt_clr = '0;
    check_val("b2b.total_width", hi, 2 * MP);

    // Test-reset override is combinational.
    testmode   = 1'b1;
    test_rst_n = 1'b0;
    #1 check_val("tm.rst_asserted", req_out, 3'b011);
    test_rst_n = 1'b1;
    #1 check_val("tm.rst_released", req_out, 3'b100);
    for (int k = 0; k < 14; k++) begin
      raw_req = (k < 3) ? AH : ~AH;
      test_rst_n = k[2];
      step("tm_activity");
    end
    check_val("tm.flags_updated", evt_flag, 3'b111);
    testmode = 1'b0;
    evt_clr  = 3'b111;
    step("clr_all");
    evt_clr  = '0;
    for (int k = 0; k < 10; k++) step("settle");

    // All channels requested together assert together.
    raw_req = AH;
    step("simul");
    raw_req = ~AH;
    step("simul");
    step("simul");
    check_val("simul.req_out", req_out, 3'b011);
    check_val("simul.flags",   evt_flag, 3'b111);
    for (int k = 0; k < 10; k++) step("simul_tail");

    // Randomised traffic.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) raw_req = 3'($urandom);
      evt_clr = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
      if ($urandom_range(0, 49) == 0) testmode = ~testmode;
      test_rst_n = ($urandom_range(0, 1) == 1);
      step("rand");
    end
    testmode = 1'b0;
    evt_clr  = '0;

    // Asynchronous reset in the middle of a ch0 pulse.
    raw_req = ~AH;
    for (int k = 0; k < 12; k++) step("pre_mid");
    raw_req[0] = 1'b1;
    for (int k = 0; k < 5; k++) step("mid");
    check_val("mid.active", req_out[0], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_val("mid.async_req_out", req_out, 3'b100);
    check_val("mid.async_flag",    evt_flag, 3'b000);
    check_val("mid.async_busy",    busy, 1'b0);
    model_reset();
    @(negedge clk);
    raw_req = ~AH;
    step("mid_rst");
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) step("post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
